// File: rtl/kf8237_address_count_registers.sv
// KF8237 per-channel base/current address and word count registers with the byte-pointer flip-flop.
// Optional feature: define KF8237_AUTOINITIALIZE_EN to reload current registers from base on terminal count.
module kf8237_address_count_registers (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  internal_data_bus,
  input  logic [3:0]  write_base_and_current_address,
  input  logic [3:0]  write_base_and_current_word_count,
  input  logic        clear_byte_pointer,
  input  logic        set_byte_pointer,
  input  logic        master_clear,
  input  logic [3:0]  read_current_address,
  input  logic [3:0]  read_current_word_count,
  input  logic [1:0]  transfer_channel,
  input  logic        update_address_and_count,
  input  logic [3:0]  decrement_address,
  input  logic [3:0]  autoinitialize,
  output logic [7:0]  read_data,
  output logic [15:0] transfer_address,
  output logic [15:0] transfer_word_count,
  output logic        terminal_count,
  output logic [3:0]  terminal_count_event
);

  logic [15:0] base_address_q    [4];
  logic [15:0] base_address_d    [4];
  logic [15:0] current_address_q [4];
  logic [15:0] current_address_d [4];
  logic [15:0] base_count_q      [4];
  logic [15:0] base_count_d      [4];
  logic [15:0] current_count_q   [4];
  logic [15:0] current_count_d   [4];

  logic        byte_pointer_q;
  logic        byte_pointer_d;
  logic        prev_read_q;
  logic        prev_read_d;
  logic [3:0]  terminal_count_event_q;
  logic [3:0]  terminal_count_event_d;

  logic        any_write;
  logic        any_read;
  logic        read_release;
  logic [15:0] read_word;

`ifndef KF8237_AUTOINITIALIZE_EN
  logic unused_autoinitialize;
  assign unused_autoinitialize = ^autoinitialize;
`endif

  function automatic logic [15:0] step_address(input logic [15:0] addr, input logic dec);
    step_address = dec ? (addr - 16'd1) : (addr + 16'd1);
  endfunction

  assign any_write    = (|write_base_and_current_address) | (|write_base_and_current_word_count);
  assign any_read     = (|read_current_address) | (|read_current_word_count);
  assign read_release = prev_read_q & ~any_read;
  assign prev_read_d  = any_read;

  // Pointer: clears dominate set, set dominates the write/read toggle.
  always_comb begin
    byte_pointer_d = byte_pointer_q;
    if (master_clear || clear_byte_pointer) begin
      byte_pointer_d = 1'b0;
    end else if (set_byte_pointer) begin
      byte_pointer_d = 1'b1;
    end else if (any_write || read_release) begin
      byte_pointer_d = ~byte_pointer_q;
    end
  end

  // Transfer update first, then CPU byte writes override only the addressed byte.
  always_comb begin
    terminal_count_event_d = 4'b0000;
    for (int ch = 0; ch < 4; ch++) begin
      base_address_d[ch]    = base_address_q[ch];
      current_address_d[ch] = current_address_q[ch];
      base_count_d[ch]      = base_count_q[ch];
      current_count_d[ch]   = current_count_q[ch];

      if (update_address_and_count && (transfer_channel == 2'(ch))) begin
        terminal_count_event_d[ch] = (current_count_q[ch] == 16'h0000);
`ifdef KF8237_AUTOINITIALIZE_EN
        if ((current_count_q[ch] == 16'h0000) && autoinitialize[ch]) begin
          current_address_d[ch] = base_address_q[ch];
          current_count_d[ch]   = base_count_q[ch];
        end else begin
          current_address_d[ch] = step_address(current_address_q[ch], decrement_address[ch]);
          current_count_d[ch]   = current_count_q[ch] - 16'd1;
        end
`else
        current_address_d[ch] = step_address(current_address_q[ch], decrement_address[ch]);
        current_count_d[ch]   = current_count_q[ch] - 16'd1;
`endif
      end

      if (write_base_and_current_address[ch]) begin
        if (byte_pointer_q) begin
          base_address_d[ch][15:8]    = internal_data_bus;
          current_address_d[ch][15:8] = internal_data_bus;
        end else begin
          base_address_d[ch][7:0]     = internal_data_bus;
          current_address_d[ch][7:0]  = internal_data_bus;
        end
      end

      if (write_base_and_current_word_count[ch]) begin
        if (byte_pointer_q) begin
          base_count_d[ch][15:8]    = internal_data_bus;
          current_count_d[ch][15:8] = internal_data_bus;
        end else begin
          base_count_d[ch][7:0]     = internal_data_bus;
          current_count_d[ch][7:0]  = internal_data_bus;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < 4; ch++) begin
        base_address_q[ch]    <= 16'h0000;
        current_address_q[ch] <= 16'h0000;
        base_count_q[ch]      <= 16'h0000;
        current_count_q[ch]   <= 16'h0000;
      end
      byte_pointer_q         <= 1'b0;
      prev_read_q            <= 1'b0;
      terminal_count_event_q <= 4'b0000;
    end else begin
      for (int ch = 0; ch < 4; ch++) begin
        base_address_q[ch]    <= base_address_d[ch];
        current_address_q[ch] <= current_address_d[ch];
        base_count_q[ch]      <= base_count_d[ch];
        current_count_q[ch]   <= current_count_d[ch];
      end
      byte_pointer_q         <= byte_pointer_d;
      prev_read_q            <= prev_read_d;
      terminal_count_event_q <= terminal_count_event_d;
    end
  end

  // Lowest-index address strobe wins, then lowest-index count strobe.
  always_comb begin
    read_word = 16'h0000;
    for (int ch = 3; ch >= 0; ch--) begin
      if (read_current_word_count[ch]) begin
        read_word = current_count_q[ch];
      end
    end
    for (int ch = 3; ch >= 0; ch--) begin
      if (read_current_address[ch]) begin
        read_word = current_address_q[ch];
      end
    end
  end

  assign read_data            = !any_read ? 8'h00 : (byte_pointer_q ? read_word[15:8] : read_word[7:0]);
  assign transfer_address     = current_address_q[transfer_channel];
  assign transfer_word_count  = current_count_q[transfer_channel];
  assign terminal_count       = (current_count_q[transfer_channel] == 16'h0000);
  assign terminal_count_event = terminal_count_event_q;

endmodule

// File: tb/tb_kf8237_address_count_registers.sv
// Scoreboard bench for kf8237_address_count_registers: expectations queued at stimulus, popped at sampling.
module tb_kf8237_address_count_registers;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  internal_data_bus = 8'h00;
  logic [3:0]  write_base_and_current_address = 4'h0;
  logic [3:0]  write_base_and_current_word_count = 4'h0;
  logic        clear_byte_pointer = 1'b0;
  logic        set_byte_pointer = 1'b0;
  logic        master_clear = 1'b0;
  logic [3:0]  read_current_address = 4'h0;
  logic [3:0]  read_current_word_count = 4'h0;
  logic [1:0]  transfer_channel = 2'd0;
  logic        update_address_and_count = 1'b0;
  logic [3:0]  decrement_address = 4'h0;
  logic [3:0]  autoinitialize = 4'h0;
  logic [7:0]  read_data;
  logic [15:0] transfer_address;
  logic [15:0] transfer_word_count;
  logic        terminal_count;
  logic [3:0]  terminal_count_event;

  kf8237_address_count_registers dut (
    .clock                             (clock),
    .reset                             (reset),
    .internal_data_bus                 (internal_data_bus),
    .write_base_and_current_address    (write_base_and_current_address),
    .write_base_and_current_word_count (write_base_and_current_word_count),
    .clear_byte_pointer                (clear_byte_pointer),
    .set_byte_pointer                  (set_byte_pointer),
    .master_clear                      (master_clear),
    .read_current_address              (read_current_address),
    .read_current_word_count           (read_current_word_count),
    .transfer_channel                  (transfer_channel),
    .update_address_and_count          (update_address_and_count),
    .decrement_address                 (decrement_address),
    .autoinitialize                    (autoinitialize),
    .read_data                         (read_data),
    .transfer_address                  (transfer_address),
    .transfer_word_count               (transfer_word_count),
    .terminal_count                    (terminal_count),
    .terminal_count_event              (terminal_count_event)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [15:0] value;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [15:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [15:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 16'(sb_q.size()), 16'd1);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.value);
    end
  endtask

  task automatic write_byte(input logic is_count, input int ch, input logic [7:0] data);
    @(negedge clock);
    internal_data_bus = data;
    if (is_count) write_base_and_current_word_count[ch] = 1'b1;
    else          write_base_and_current_address[ch] = 1'b1;
    @(negedge clock);
    write_base_and_current_address    = 4'h0;
    write_base_and_current_word_count = 4'h0;
  endtask

  task automatic write_word(input logic is_count, input int ch, input logic [15:0] data);
    write_byte(is_count, ch, data[7:0]);
    write_byte(is_count, ch, data[15:8]);
  endtask

  task automatic read_byte(input string tag, input logic [3:0] amask, input logic [3:0] cmask,
                           input logic [7:0] exp);
    @(negedge clock);
    read_current_address    = amask;
    read_current_word_count = cmask;
    push_exp(tag, {8'h00, exp});
    #1 pop_cmp({8'h00, read_data});
    @(negedge clock);
    read_current_address    = 4'h0;
    read_current_word_count = 4'h0;
    @(negedge clock);
  endtask

  task automatic pulse_ctrl(input int which);
    @(negedge clock);
    case (which)
      0:       clear_byte_pointer = 1'b1;
      1:       master_clear = 1'b1;
      default: set_byte_pointer = 1'b1;
    endcase
    @(negedge clock);
    clear_byte_pointer = 1'b0;
    master_clear       = 1'b0;
    set_byte_pointer   = 1'b0;
  endtask

  task automatic update_check(input string tag, input logic [15:0] ea, input logic [15:0] ec,
                              input logic [3:0] ev);
    push_exp({tag, "_addr"}, ea);
    push_exp({tag, "_cnt"}, ec);
    push_exp({tag, "_evt"}, {12'h000, ev});
    push_exp({tag, "_evt_off"}, 16'h0000);
    @(negedge clock);
    update_address_and_count = 1'b1;
    @(negedge clock);
    update_address_and_count = 1'b0;
    #1;
    pop_cmp(transfer_address);
    pop_cmp(transfer_word_count);
    pop_cmp({12'h000, terminal_count_event});
    @(negedge clock);
    #1 pop_cmp({12'h000, terminal_count_event});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    push_exp("rst_read_data", 16'h0000);
    push_exp("rst_count", 16'h0000);
    push_exp("rst_tc", 16'h0001);
    #1;
    pop_cmp({8'h00, read_data});
    pop_cmp(transfer_word_count);
    pop_cmp({15'h0000, terminal_count});
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    push_exp("post_rst_evt", 16'h0000);
    #1 pop_cmp({12'h000, terminal_count_event});

    // Channel 1 address write and two byte reads
    write_byte(1'b0, 1, 8'h34);
    write_byte(1'b0, 1, 8'h12);
    transfer_channel = 2'd1;
    push_exp("ch1_addr", 16'h1234);
    #1 pop_cmp(transfer_address);
    read_byte("ch1_rd_lo", 4'b0010, 4'b0000, 8'h34);
    read_byte("ch1_rd_hi", 4'b0010, 4'b0000, 8'h12);

    // Channel 2 incrementing with count wrap and terminal count event
    write_word(1'b1, 2, 16'h0002);
    write_word(1'b0, 2, 16'hFFFF);
    transfer_channel = 2'd2;
    push_exp("ch2_tc_before", 16'h0000);
    #1 pop_cmp({15'h0000, terminal_count});
    update_check("ch2_u1", 16'h0000, 16'h0001, 4'b0000);
    update_check("ch2_u2", 16'h0001, 16'h0000, 4'b0000);
    push_exp("ch2_tc_at_zero", 16'h0001);
    #1 pop_cmp({15'h0000, terminal_count});
    update_check("ch2_u3", 16'h0002, 16'hFFFF, 4'b0100);

    // Channel 3 autoinitialize, decrementing
    autoinitialize    = 4'b1000;
    decrement_address = 4'b1000;
    write_word(1'b0, 3, 16'h1000);
    write_word(1'b1, 3, 16'h0000);
    transfer_channel = 2'd3;
`ifdef KF8237_AUTOINITIALIZE_EN
    update_check("ch3_auto", 16'h1000, 16'h0000, 4'b1000);
`else
    update_check("ch3_noauto", 16'h0FFF, 16'hFFFF, 4'b1000);
`endif

    // Byte pointer control on channel 0
    transfer_channel = 2'd0;
    pulse_ctrl(0);
    write_byte(1'b0, 0, 8'h11);
    pulse_ctrl(0);
    write_byte(1'b0, 0, 8'hAA);
    push_exp("clr_ptr_write", 16'h00AA);
    #1 pop_cmp(transfer_address);
    pulse_ctrl(0);
    write_byte(1'b0, 0, 8'h33);
    pulse_ctrl(1);
    push_exp("mclr_keeps_regs", 16'h0033);
    #1 pop_cmp(transfer_address);
    write_byte(1'b0, 0, 8'hBB);
    push_exp("mclr_ptr_write", 16'h00BB);
    #1 pop_cmp(transfer_address);
    pulse_ctrl(0);
    pulse_ctrl(2);
    write_byte(1'b0, 0, 8'h77);
    push_exp("set_ptr_write", 16'h77BB);
    #1 pop_cmp(transfer_address);

    // Simultaneous high-byte write and update on channel 1
    transfer_channel = 2'd1;
    pulse_ctrl(0);
    write_word(1'b1, 1, 16'h0010);
    pulse_ctrl(2);
    push_exp("sim_cnt", 16'h550F);
    push_exp("sim_addr", 16'h1235);
    @(negedge clock);
    internal_data_bus = 8'h55;
    write_base_and_current_word_count = 4'b0010;
    update_address_and_count = 1'b1;
    @(negedge clock);
    write_base_and_current_word_count = 4'h0;
    update_address_and_count = 1'b0;
    #1;
    pop_cmp(transfer_word_count);
    pop_cmp(transfer_address);

    // Back-to-back updates
    push_exp("b2b_addr", 16'h1237);
    push_exp("b2b_cnt", 16'h550D);
    @(negedge clock);
    update_address_and_count = 1'b1;
    @(negedge clock);
    @(negedge clock);
    update_address_and_count = 1'b0;
    #1;
    pop_cmp(transfer_address);
    pop_cmp(transfer_word_count);

    // Read strobe priority: address ch1 beats address ch2 and count ch0
    read_byte("rd_priority", 4'b0110, 4'b0001, 8'h37);
    read_byte("rd_cnt_hi", 4'b0000, 4'b0010, 8'h55);

    // Reset mid-transfer
    push_exp("midrst_addr", 16'h0000);
    push_exp("midrst_cnt", 16'h0000);
    push_exp("midrst_evt", 16'h0000);
    @(negedge clock);
    update_address_and_count = 1'b1;
    #2 reset = 1'b1;
    #1;
    pop_cmp(transfer_address);
    pop_cmp(transfer_word_count);
    pop_cmp({12'h000, terminal_count_event});
    update_address_and_count = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check_val("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
